// File: rtl/layer_register_bank.sv
// Double-buffered per-layer register field: host writes go to a shadow bank,
// and a vsync-aligned sweep copies dirty entries into the active bank.
module layer_register_bank #(
  parameter int DATA_W = 16,
  parameter int LAYERS = 32,
  parameter int ADDR_W = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic [ADDR_W-1:0]   shadow_rd_addr,
  output logic [DATA_W-1:0]   shadow_rd_data,
  input  logic                commit_req,
  input  logic                vsync,
  input  logic [ADDR_W-1:0]   rd_addr_a,
  output logic [DATA_W-1:0]   rd_data_a,
  input  logic [ADDR_W-1:0]   rd_addr_b,
  output logic [DATA_W-1:0]   rd_data_b,
  output logic                commit_pending,
  output logic                busy,
  output logic                commit_done,
  output logic                dirty_any
);

  localparam int BYTES = DATA_W / 8;

  typedef enum logic {IDLE, COPY} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] idx_q;
  logic [DATA_W-1:0] shadow_q [LAYERS];
  logic [DATA_W-1:0] active_q [LAYERS];
  logic [LAYERS-1:0] dirty_q;
  logic [LAYERS-1:0] dirty_d;
  logic [DATA_W-1:0] shadow_wr_d;
  logic              pending_q;
  logic              done_q;
  logic [DATA_W-1:0] rd_a_q;
  logic [DATA_W-1:0] rd_b_q;

  logic wr_hit;
  logic start_copy;
  logic last_idx;

  assign wr_hit     = wr_en && (32'(wr_addr) < LAYERS);
  assign start_copy = (state_q == IDLE) && vsync && (pending_q || commit_req);
  assign last_idx   = (32'(idx_q) == LAYERS - 1);

  always_comb begin
    shadow_wr_d = shadow_q[wr_addr];
    for (int k = 0; k < BYTES; k++) begin
      if (wr_be[k]) shadow_wr_d[8*k +: 8] = wr_data[8*k +: 8];
    end
  end

  // A host write in the same cycle as the copy of that entry keeps it dirty.
  always_comb begin
    dirty_d = dirty_q;
    if (state_q == COPY) dirty_d[idx_q] = 1'b0;
    if (wr_hit) dirty_d[wr_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
      rd_a_q    <= '0;
      rd_b_q    <= '0;
      dirty_q   <= '0;
      for (int i = 0; i < LAYERS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      rd_a_q <= (32'(rd_addr_a) < LAYERS) ? active_q[rd_addr_a] : '0;
      rd_b_q <= (32'(rd_addr_b) < LAYERS) ? active_q[rd_addr_b] : '0;

      case (state_q)
        IDLE: begin
          if (start_copy) begin
            state_q <= COPY;
            idx_q   <= '0;
          end
        end
        COPY: begin
          // Clean entries still cost a cycle so commit latency is fixed.
          if (dirty_q[idx_q]) active_q[idx_q] <= shadow_q[idx_q];
          if (last_idx) begin
            state_q <= IDLE;
            idx_q   <= '0;
            done_q  <= 1'b1;
          end else begin
            idx_q <= idx_q + ADDR_W'(1);
          end
        end
      endcase

      if (start_copy) pending_q <= 1'b0;
      else if (commit_req) pending_q <= 1'b1;

      dirty_q <= dirty_d;
      if (wr_hit) shadow_q[wr_addr] <= shadow_wr_d;
    end
  end

  assign shadow_rd_data = (reset && (32'(shadow_rd_addr) < LAYERS)) ? shadow_q[shadow_rd_addr] : '0;
  assign rd_data_a      = rd_a_q;
  assign rd_data_b      = rd_b_q;
  assign commit_pending = pending_q;
  assign busy           = (state_q == COPY);
  assign commit_done    = done_q;
  assign dirty_any      = |dirty_q;

endmodule

// File: tb/tb_layer_register_bank.sv
// Bench for layer_register_bank: directed table, multi-cycle commit corners,
// randomized traffic against an array-based reference model, and a 20x32 instance.
module tb_layer_register_bank;

  localparam int L = 32;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_be;
  logic [4:0]  shadow_rd_addr;
  logic [15:0] shadow_rd_data;
  logic        commit_req;
  logic        vsync;
  logic [4:0]  rd_addr_a;
  logic [15:0] rd_data_a;
  logic [4:0]  rd_addr_b;
  logic [15:0] rd_data_b;
  logic        commit_pending;
  logic        busy;
  logic        commit_done;
  logic        dirty_any;

  logic        s_wr_en;
  logic [4:0]  s_wr_addr;
  logic [31:0] s_wr_data;
  logic [3:0]  s_wr_be;
  logic [4:0]  s_shadow_rd_addr;
  logic [31:0] s_shadow_rd_data;
  logic        s_commit_req;
  logic        s_vsync;
  logic [4:0]  s_rd_addr_a;
  logic [31:0] s_rd_data_a;
  logic [4:0]  s_rd_addr_b;
  logic [31:0] s_rd_data_b;
  logic        s_commit_pending;
  logic        s_busy;
  logic        s_commit_done;
  logic        s_dirty_any;

  int compared;
  int mismatched;

  // Reference model state: plain arrays plus a "copy in flight" cursor.
  logic [15:0] mSh  [L];
  logic [15:0] mAct [L];
  logic [L-1:0] mDirty;
  logic        mPend;
  logic        mCopying;
  int          mIdx;
  logic        mDone;

  layer_register_bank #(.DATA_W(16), .LAYERS(32), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .shadow_rd_addr(shadow_rd_addr), .shadow_rd_data(shadow_rd_data),
    .commit_req(commit_req), .vsync(vsync),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
    .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
    .commit_pending(commit_pending), .busy(busy),
    .commit_done(commit_done), .dirty_any(dirty_any)
  );

  layer_register_bank #(.DATA_W(32), .LAYERS(20), .ADDR_W(5)) dutSmall (
    .clk(clk), .reset(reset),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data), .wr_be(s_wr_be),
    .shadow_rd_addr(s_shadow_rd_addr), .shadow_rd_data(s_shadow_rd_data),
    .commit_req(s_commit_req), .vsync(s_vsync),
    .rd_addr_a(s_rd_addr_a), .rd_data_a(s_rd_data_a),
    .rd_addr_b(s_rd_addr_b), .rd_data_b(s_rd_data_b),
    .commit_pending(s_commit_pending), .busy(s_busy),
    .commit_done(s_commit_done), .dirty_any(s_dirty_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < L; i++) begin
      mSh[i]  = '0;
      mAct[i] = '0;
    end
    mDirty   = '0;
    mPend    = 1'b0;
    mCopying = 1'b0;
    mIdx     = 0;
    mDone    = 1'b0;
  endtask

  task automatic idle();
    wr_en      = 1'b0;
    commit_req = 1'b0;
    vsync      = 1'b0;
  endtask

  task automatic checkOutput(input logic [15:0] expA, input logic [15:0] expB);
    check("rd_data_a", rd_data_a, expA);
    check("rd_data_b", rd_data_b, expB);
    check("shadow_rd_data", shadow_rd_data, mSh[shadow_rd_addr]);
    check("commit_pending", commit_pending, mPend);
    check("busy", busy, mCopying);
    check("commit_done", commit_done, mDone);
    check("dirty_any", dirty_any, |mDirty);
  endtask

  // One clock: advance the model with the current inputs, then compare.
  task automatic applyStimulus();
    logic [15:0] expA;
    logic [15:0] expB;
    logic        started;
    logic        newDone;
    expA    = mAct[rd_addr_a];
    expB    = mAct[rd_addr_b];
    started = 1'b0;
    newDone = 1'b0;
    if (mCopying) begin
      if (mDirty[mIdx]) begin
        mAct[mIdx]   = mSh[mIdx];
        mDirty[mIdx] = 1'b0;
      end
      if (mIdx == L - 1) begin
        mCopying = 1'b0;
        newDone  = 1'b1;
      end else begin
        mIdx++;
      end
    end else if (vsync && (mPend || commit_req)) begin
      started  = 1'b1;
      mCopying = 1'b1;
      mIdx     = 0;
    end
    if (started) mPend = 1'b0;
    else if (commit_req) mPend = 1'b1;
    if (wr_en && (int'(wr_addr) < L)) begin
      for (int k = 0; k < 2; k++) begin
        if (wr_be[k]) mSh[wr_addr][8*k +: 8] = wr_data[8*k +: 8];
      end
      mDirty[wr_addr] = 1'b1;
    end
    mDone = newDone;
    @(posedge clk);
    #1;
    checkOutput(expA, expB);
    @(negedge clk);
  endtask

  task automatic waitDone(input int budget, output int busyCnt, output int doneAt);
    busyCnt = 0;
    doneAt  = -1;
    for (int k = 1; k <= budget; k++) begin
      applyStimulus();
      if (busy) busyCnt++;
      if (commit_done) begin
        doneAt = k;
        break;
      end
    end
  endtask

  task automatic step2();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [15:0] data;
    logic [1:0]  be;
    logic [15:0] expSh;
    logic        expDirty;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int busyCnt;
    int doneAt;
    logic prevVsync;

    compared   = 0;
    mismatched = 0;

    vecs[0] = '{1'b1, 5'd3, 16'hABCD, 2'b11, 16'hABCD, 1'b1};
    vecs[1] = '{1'b1, 5'd3, 16'h1234, 2'b01, 16'hAB34, 1'b1};
    vecs[2] = '{1'b0, 5'd3, 16'hFFFF, 2'b11, 16'hAB34, 1'b1};
    vecs[3] = '{1'b1, 5'd7, 16'h5A5A, 2'b00, 16'h0000, 1'b1};
    vecs[4] = '{1'b1, 5'd7, 16'hC3C3, 2'b10, 16'hC300, 1'b1};

    reset = 1'b0;
    idle();
    wr_addr = '0; wr_data = '0; wr_be = '0;
    shadow_rd_addr = '0; rd_addr_a = '0; rd_addr_b = '0;
    s_wr_en = 1'b0; s_wr_addr = '0; s_wr_data = '0; s_wr_be = '0;
    s_shadow_rd_addr = '0; s_commit_req = 1'b0; s_vsync = 1'b0;
    s_rd_addr_a = '0; s_rd_addr_b = '0;
    modelReset();

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_pending", commit_pending, 1'b0);
    check("rst_done", commit_done, 1'b0);
    check("rst_dirty_any", dirty_any, 1'b0);
    check("rst_rd_a", rd_data_a, 16'h0);
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] reset readout of every entry");
    for (int a = 0; a < L; a++) begin
      rd_addr_a = 5'(a);
      rd_addr_b = 5'(L - 1 - a);
      shadow_rd_addr = 5'(a);
      applyStimulus();
    end

    $display("[TB] table-driven shadow writes");
    rd_addr_a = 5'd3;
    for (int i = 0; i < 5; i++) begin
      wr_en = vecs[i].we;
      wr_addr = vecs[i].addr;
      wr_data = vecs[i].data;
      wr_be = vecs[i].be;
      shadow_rd_addr = vecs[i].addr;
      applyStimulus();
      check("tbl_shadow", shadow_rd_data, vecs[i].expSh);
      check("tbl_dirty_any", dirty_any, vecs[i].expDirty);
      check("tbl_active3", rd_data_a, 16'h0000);
    end
    idle();

    $display("[TB] commit with vsync five cycles after request");
    commit_req = 1'b1;
    applyStimulus();
    commit_req = 1'b0;
    repeat (4) applyStimulus();
    vsync = 1'b1;
    applyStimulus();
    vsync = 1'b0;
    busyCnt = busy ? 1 : 0;
    begin
      int extraBusy;
      waitDone(40, extraBusy, doneAt);
      busyCnt += extraBusy;
    end
    check("commit1_busy_cycles", 32'(busyCnt), 32'd32);
    check("commit1_done_at", 32'(doneAt), 32'd32);
    rd_addr_a = 5'd3;
    rd_addr_b = 5'd7;
    applyStimulus();
    check("commit1_active3", rd_data_a, 16'hAB34);
    check("commit1_active7", rd_data_b, 16'hC300);
    check("commit1_dirty_any", dirty_any, 1'b0);

    $display("[TB] vsync with nothing pending");
    vsync = 1'b1;
    applyStimulus();
    vsync = 1'b0;
    check("idle_vsync_busy", busy, 1'b0);
    repeat (3) applyStimulus();
    check("idle_vsync_active3", rd_data_a, 16'hAB34);

    $display("[TB] writes colliding with a running copy");
    commit_req = 1'b1;
    applyStimulus();
    commit_req = 1'b0;
    vsync = 1'b1;
    applyStimulus();
    vsync = 1'b0;
    repeat (2) applyStimulus();
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 16'h1111; wr_be = 2'b11;
    applyStimulus();
    wr_addr = 5'd31; wr_data = 16'h2222;
    applyStimulus();
    wr_en = 1'b0;
    waitDone(40, busyCnt, doneAt);
    check("collide_done_seen", 32'(doneAt >= 0), 32'd1);
    rd_addr_a = 5'd31;
    rd_addr_b = 5'd0;
    applyStimulus();
    check("collide_active31", rd_data_a, 16'h2222);
    check("collide_active0", rd_data_b, 16'h0000);
    check("collide_dirty_any", dirty_any, 1'b1);

    $display("[TB] reset in the middle of a copy");
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 16'h5555; wr_be = 2'b11;
    applyStimulus();
    wr_addr = 5'd20; wr_data = 16'h2020;
    applyStimulus();
    wr_en = 1'b0;
    commit_req = 1'b1;
    vsync = 1'b1;
    applyStimulus();
    idle();
    rd_addr_a = 5'd5;
    shadow_rd_addr = 5'd20;
    repeat (10) applyStimulus();
    check("precut_active5", rd_data_a, 16'h5555);
    check("precut_busy", busy, 1'b1);
    reset = 1'b0;
    #1;
    check("cut_busy", busy, 1'b0);
    check("cut_pending", commit_pending, 1'b0);
    check("cut_done", commit_done, 1'b0);
    check("cut_dirty_any", dirty_any, 1'b0);
    check("cut_rd_a", rd_data_a, 16'h0);
    check("cut_shadow_rd", shadow_rd_data, 16'h0);
    modelReset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 16'h0F0F; wr_be = 2'b11;
    applyStimulus();
    wr_en = 1'b0;
    commit_req = 1'b1;
    vsync = 1'b1;
    applyStimulus();
    idle();
    waitDone(40, busyCnt, doneAt);
    check("recommit_done_at", 32'(doneAt), 32'd32);
    rd_addr_a = 5'd9;
    rd_addr_b = 5'd5;
    applyStimulus();
    check("recommit_active9", rd_data_a, 16'h0F0F);
    check("recommit_active5", rd_data_b, 16'h0000);

    $display("[TB] randomized traffic");
    prevVsync = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      wr_en          = ($urandom_range(0, 2) == 0);
      wr_addr        = 5'($urandom);
      wr_data        = 16'($urandom);
      wr_be          = 2'($urandom);
      shadow_rd_addr = 5'($urandom);
      rd_addr_a      = 5'($urandom);
      rd_addr_b      = 5'($urandom);
      commit_req     = ($urandom_range(0, 15) == 0);
      vsync          = !prevVsync && ($urandom_range(0, 39) == 0);
      prevVsync      = vsync;
      applyStimulus();
    end
    idle();

    $display("[TB] 20-layer, 32-bit instance");
    s_wr_en = 1'b1; s_wr_addr = 5'd25; s_wr_data = 32'hFFFF_FFFF; s_wr_be = 4'hF;
    step2();
    s_wr_en = 1'b0;
    s_shadow_rd_addr = 5'd25;
    #1;
    check("small_oor_dirty", s_dirty_any, 1'b0);
    check("small_oor_shadow", s_shadow_rd_data, 32'h0);
    s_wr_en = 1'b1; s_wr_addr = 5'd19; s_wr_data = 32'hDEAD_BEEF; s_wr_be = 4'hF;
    step2();
    s_wr_en = 1'b0;
    s_shadow_rd_addr = 5'd19;
    #1;
    check("small_shadow19", s_shadow_rd_data, 32'hDEAD_BEEF);
    check("small_dirty", s_dirty_any, 1'b1);
    s_commit_req = 1'b1;
    s_vsync = 1'b1;
    step2();
    s_commit_req = 1'b0;
    s_vsync = 1'b0;
    busyCnt = s_busy ? 1 : 0;
    doneAt = -1;
    for (int k = 1; k <= 30; k++) begin
      step2();
      if (s_busy) busyCnt++;
      if (s_commit_done) begin
        doneAt = k;
        break;
      end
    end
    check("small_busy_cycles", 32'(busyCnt), 32'd20);
    check("small_done_at", 32'(doneAt), 32'd20);
    s_rd_addr_a = 5'd19;
    s_rd_addr_b = 5'd25;
    step2();
    check("small_active19", s_rd_data_a, 32'hDEAD_BEEF);
    check("small_active25", s_rd_data_b, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/layer_register_bank.md
Name: layer_register_bank

Overview:
- Parametrised, double-buffered store holding one register field for every layer, e.g. register 0 of all layers.
- Host writes land in a shadow bank with byte enables and per-entry dirty tracking.
- On a requested commit, dirty entries are copied to the active bank at the next vsync.
- The layer pipeline reads only the active bank through two registered read ports, so register changes never tear mid-frame.

Parameters:
- DATA_W, 16, entry width in bits; must be a multiple of 8.
- LAYERS, 32, number of entries (layers); 2..256.
- ADDR_W, 5, address width; must satisfy 2^ADDR_W >= LAYERS.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  shadow write strobe.
- wr_addr  in  ADDR_W  shadow write index.
- wr_data  in  DATA_W  shadow write data.
- wr_be  in  DATA_W/8  byte enables; bit k covers bits [8k+7:8k].
- shadow_rd_addr  in  ADDR_W  host readback index.
- shadow_rd_data  out  DATA_W  combinational shadow readback.
- commit_req  in  1  request a commit at the next vsync.
- vsync  in  1  frame-boundary pulse, one cycle wide.
- rd_addr_a  in  ADDR_W  active-bank read port A index.
- rd_data_a  out  DATA_W  registered active-bank data, port A.
- rd_addr_b  in  ADDR_W  active-bank read port B index.
- rd_data_b  out  DATA_W  registered active-bank data, port B.
- commit_pending  out  1  commit requested, not yet started.
- busy  out  1  copy in progress.
- commit_done  out  1  one-cycle pulse when a copy finishes.
- dirty_any  out  1  OR of all dirty bits.

Behaviour:
- Reset (reset low, async):
  - Shadow bank, active bank and all dirty bits are cleared to 0.
  - State returns to IDLE; copy index is 0.
  - rd_data_a, rd_data_b, commit_pending, busy, commit_done and dirty_any are all 0.
  - shadow_rd_data reads 0 while reset is low.
  - Reset during COPY aborts the copy; no partial-commit state survives.
- Shadow write: on a posedge with wr_en and wr_addr < LAYERS:
  - Each enabled byte of shadow[wr_addr] is updated.
  - dirty[wr_addr] is set to 1, even if wr_be = 0.
  - Writes with wr_addr >= LAYERS are ignored.
- shadow_rd_data: shadow[shadow_rd_addr], combinational. An out-of-range address returns 0.
- Active reads: rd_data_x <= active[rd_addr_x] each posedge, giving 1-cycle latency.
  - Out-of-range address returns 0.
  - A read of an entry being copied in the same cycle returns the pre-copy value (read-before-write).
- commit_pending:
  - Set by commit_req in any state.
  - Cleared when COPY starts.
  - commit_req during COPY re-arms pending for the next vsync.
- State machine:
  - IDLE -> COPY on a posedge where vsync=1 and (commit_pending or commit_req).
  - vsync with nothing pending does nothing; vsync during COPY is ignored.
  - COPY: busy=1; copy index i runs 0..LAYERS-1, one entry per cycle.
    - If dirty[i]: active[i] <= shadow[i] and dirty[i] is cleared.
    - Clean entries are skipped but still take one cycle, so latency is fixed.
  - After index LAYERS-1 the state returns to IDLE, with commit_done=1 for exactly one cycle and busy=0 that cycle.
  - Timing: vsync sampled at edge T -> busy is high for cycles T+1..T+LAYERS -> commit_done is high in cycle T+LAYERS+1.
- Write colliding with the copy:
  - Write to index == i in the same cycle: active gets the old shadow value, the write lands in shadow, and dirty[i] stays 1.
  - Write to index < i: re-dirties the entry for the next commit.
  - Write to index > i: the entry is copied with its new value.
- dirty_any: combinational OR of the dirty bits.

Test Plan:
- Reset, then read every address on both ports -> all 0; commit_pending, busy, commit_done and dirty_any are 0.
- Write addr 3 = 0xABCD with be=11, then be=01 data 0x1234 -> shadow_rd_data = 0xAB34. Active addr 3 reads 0. dirty_any=1.
- commit_req, then vsync 5 cycles later -> busy high for 32 cycles, then commit_done for 1 cycle. rd_data_a(3) = 0xAB34 one cycle after the read address is applied. dirty_any=0.
- vsync without commit_req -> no busy, active unchanged.
- During COPY, write addr 0 (already passed) = 0x1111 and addr 31 = 0x2222 -> after done: active[31]=0x2222, active[0] unchanged, dirty_any=1.
- Assert reset mid-COPY at index 10 -> all outputs 0 immediately; after release, a new commit copies from clean state. Also run with LAYERS=20, DATA_W=32 and check the out-of-range write at addr 25 is ignored.
